ula_multiciclo: RTL and testbench

Parametrised, registered successor to the 32-bit ULA for the MIPS datapath. Keeps the eight single-cycle logic/arithmetic operations and adds iterative unsigned multiply and divide with HI/LO results. Uses a start/busy/done handshake so the multicycle control FSM can stall on long operations. Sits in the execute stage; the control unit drives `inicio` and waits for `pronto`.

---
 rtl/ula_multiciclo.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// Registered multicycle ALU: single-cycle logic/arithmetic ops plus iterative MULTU/DIVU (HI/LO).
// Define ULA_SINAL_EN to add signed MULT (1010) and DIV (1011) with a sign fix-up cycle.
module ula_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inicio,
   input  logic [3:0]       ULAcontrole,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ocupado,
   output logic             pronto,
   output logic [WIDTH-1:0] ULAsaida,
   output logic [WIDTH-1:0] hi,
   output logic             cout,
   output logic             zero,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_NOR   = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NAND  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;
`ifdef ULA_SINAL_EN
   localparam logic [3:0] OP_MULT  = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
`endif

   typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

   // Single-cycle ops: returns {cout, result}
   function automatic logic [WIDTH:0] opera(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y, input logic c);
      logic [WIDTH:0] t;
      t = '0;
      case (op)
         OP_AND:  t = {1'b0, x & y};
         OP_OR:   t = {1'b0, x | y};
         OP_ADD:  t = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
         OP_NOR:  t = {1'b0, ~(x | y)};
         OP_XOR:  t = {1'b0, x ^ y};
         OP_NAND: t = {1'b0, ~(x & y)};
         OP_SUB: begin
            t = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
            t[WIDTH] = ~t[WIDTH];  // carry = no borrow
         end
         OP_SLT:  t = {{WIDTH{1'b0}}, ($signed(x) < $signed(y))};
         default: t = '0;
      endcase
      return t;
   endfunction

`ifdef ULA_SINAL_EN
   function automatic logic [WIDTH-1:0] modulo(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
`endif

   estado_t          state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opb_q, opb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d, nega_q, nega_d, dz_q, dz_d, sinal_q, sinal_d, fix_q, fix_d;
   logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
   logic             cout_q, cout_d, zero_q, zero_d, divz_q, divz_d;

   logic             eh_mul;
   logic [WIDTH:0]   soma, desl, dif;
   logic [WIDTH-1:0] step_acc, step_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] fix_res, fix_hi;
   logic [WIDTH:0]   simples;
   logic             fin;
   logic [WIDTH-1:0] fin_res, fin_hi;

   // One shift-add or restoring shift-subtract step; acc holds HI/remainder, lo holds LO/quotient
   always_comb begin
      eh_mul = ~op_q[0];
      soma = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      desl = {acc_q, lo_q[WIDTH-1]};
      dif  = desl - {1'b0, opb_q};
      step_acc = '0;
      step_lo  = '0;
      if (eh_mul) begin
         step_acc = soma[WIDTH:1];
         step_lo  = {soma[0], lo_q[WIDTH-1:1]};
      end else if (desl >= {1'b0, opb_q}) begin
         step_acc = dif[WIDTH-1:0];
         step_lo  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         step_acc = desl[WIDTH-1:0];
         step_lo  = {lo_q[WIDTH-2:0], 1'b0};
      end
      prod_fix = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
      if (eh_mul) begin
         fix_res = prod_fix[WIDTH-1:0];
         fix_hi  = prod_fix[2*WIDTH-1:WIDTH];
      end else begin
         fix_res = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
         fix_hi  = nega_q ? -acc_q : acc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      nega_d  = nega_q;
      dz_d    = dz_q;
      sinal_d = sinal_q;
      fix_d   = fix_q;
      res_d   = res_q;
      hi_d    = hi_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      divz_d  = divz_q;
      simples = opera(ULAcontrole, a, b, cin);
      fin     = 1'b0;
      fin_res = '0;
      fin_hi  = '0;
      case (state_q)
         OCIOSO: begin
            if (inicio) begin
               op_d    = ULAcontrole;
               cnt_d   = CW'(WIDTH);
               acc_d   = '0;
               neg_d   = 1'b0;
               nega_d  = 1'b0;
               dz_d    = 1'b0;
               sinal_d = 1'b0;
               fix_d   = 1'b0;
               case (ULAcontrole)
                  OP_MULTU: begin
                     lo_d    = b;
                     opb_d   = a;
                     state_d = CALC;
                  end
                  OP_DIVU: begin
                     lo_d    = a;
                     opb_d   = b;
                     dz_d    = (b == '0);
                     state_d = CALC;
                  end
`ifdef ULA_SINAL_EN
                  OP_MULT: begin
                     lo_d    = modulo(b);
                     opb_d   = modulo(a);
                     neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                     sinal_d = 1'b1;
                     state_d = CALC;
                  end
                  OP_DIV: begin
                     lo_d    = modulo(a);
                     opb_d   = modulo(b);
                     neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                     nega_d  = a[WIDTH-1];
                     dz_d    = (b == '0);
                     sinal_d = 1'b1;
                     state_d = CALC;
                  end
`endif
                  default: begin
                     res_d   = simples[WIDTH-1:0];
                     hi_d    = '0;
                     cout_d  = simples[WIDTH];
                     zero_d  = (simples[WIDTH-1:0] == '0);
                     divz_d  = 1'b0;
                     state_d = FIM;
                  end
               endcase
            end
         end
         CALC: begin
            if (fix_q) begin
               fix_d   = 1'b0;
               fin     = 1'b1;
               fin_res = fix_res;
               fin_hi  = fix_hi;
            end else begin
               acc_d = step_acc;
               lo_d  = step_lo;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  if (sinal_q) begin
                     fix_d = 1'b1;
                  end else begin
                     fin     = 1'b1;
                     fin_res = step_lo;
                     fin_hi  = step_acc;
                  end
               end
            end
         end
         FIM:     state_d = OCIOSO;
         default: state_d = OCIOSO;
      endcase
      if (fin) begin
         res_d   = fin_res;
         hi_d    = fin_hi;
         cout_d  = 1'b0;
         zero_d  = (fin_res == '0);
         divz_d  = dz_q;
         state_d = FIM;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= OCIOSO;
         op_q    <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opb_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         nega_q  <= 1'b0;
         dz_q    <= 1'b0;
         sinal_q <= 1'b0;
         fix_q   <= 1'b0;
         res_q   <= '0;
         hi_q    <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         divz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opb_q   <= opb_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         nega_q  <= nega_d;
         dz_q    <= dz_d;
         sinal_q <= sinal_d;
         fix_q   <= fix_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         divz_q  <= divz_d;
      end
   end

   assign ocupado  = (state_q == CALC);
   assign pronto   = (state_q == FIM);
   assign ULAsaida = res_q;
   assign hi       = hi_q;
   assign cout     = cout_q;
   assign zero     = zero_q;
   assign div_zero = divz_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo (WIDTH = 32, default build).
module tb_ula_multiciclo;
   logic        clk = 1'b0;
   logic        reset, inicio, cin;
   logic [3:0]  ULAcontrole;
   logic [31:0] a, b;
   logic        ocupado, pronto, cout, zero, div_zero;
   logic [31:0] ULAsaida, hi;
   int checks = 0;
   int failures = 0;

   ula_multiciclo #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .inicio(inicio), .ULAcontrole(ULAcontrole),
      .a(a), .b(b), .cin(cin), .ocupado(ocupado), .pronto(pronto),
      .ULAsaida(ULAsaida), .hi(hi), .cout(cout), .zero(zero), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Issues one operation and waits (bounded) for pronto; lat = 0 on timeout
   task automatic executa(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input int maxc, output int lat, output int ocup);
      @(negedge clk);
      ULAcontrole = op; a = x; b = y; cin = c; inicio = 1'b1;
      lat = 0; ocup = 0;
      for (int n = 1; n <= maxc; n++) begin
         @(negedge clk);
         inicio = 1'b0;
         a = $urandom; b = $urandom; cin = 1'b0;
         if (ocupado) ocup++;
         if (pronto) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; inicio = 1'b0; ULAcontrole = '0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ocupado, pronto, ULAsaida, hi, cout, zero, div_zero} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0",
                  {ocupado, pronto, ULAsaida, hi, cout, zero, div_zero});
      end
      reset = 1'b0;
   endtask

   task automatic test_add;
      int lat, ocup;
      executa(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5, lat, ocup);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d required=1", lat); end
      checks++;
      if ({ULAsaida, cout, zero, hi} !== {32'h0, 1'b1, 1'b1, 32'h0}) begin
         failures++;
         $display("FAIL add_result res=%h cout=%b zero=%b hi=%h required res=0 cout=1 zero=1 hi=0",
                  ULAsaida, cout, zero, hi);
      end
      @(negedge clk);
      checks++;
      if (pronto !== 1'b0) begin failures++; $display("FAIL pronto_pulse got=%b required=0", pronto); end
      executa(4'b0010, 32'h0000_0010, 32'h0000_0020, 1'b1, 5, lat, ocup);
      checks++;
      if ({ULAsaida, cout, zero} !== {32'h31, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL add_cin res=%h cout=%b zero=%b required res=31 cout=0 zero=0", ULAsaida, cout, zero);
      end
   endtask

   task automatic test_sub_slt;
      int lat, ocup;
      executa(4'b0110, 32'd5, 32'd7, 1'b0, 5, lat, ocup);
      checks++;
      if ({lat, ULAsaida, cout} !== {32'd1, 32'hFFFF_FFFE, 1'b0}) begin
         failures++;
         $display("FAIL sub lat=%0d res=%h cout=%b required lat=1 res=fffffffe cout=0", lat, ULAsaida, cout);
      end
      executa(4'b0110, 32'd9, 32'd4, 1'b1, 5, lat, ocup);
      checks++;
      if ({ULAsaida, cout} !== {32'd4, 1'b1}) begin
         failures++;
         $display("FAIL sub_noborrow res=%h cout=%b required res=4 cout=1", ULAsaida, cout);
      end
      executa(4'b0111, 32'd5, 32'd7, 1'b0, 5, lat, ocup);
      checks++;
      if ({ULAsaida, cout} !== {32'd1, 1'b0}) begin
         failures++;
         $display("FAIL slt res=%h cout=%b required res=1 cout=0", ULAsaida, cout);
      end
      executa(4'b0111, 32'd3, 32'hFFFF_FFFF, 1'b0, 5, lat, ocup);
      checks++;
      if ({ULAsaida, zero} !== {32'd0, 1'b1}) begin
         failures++;
         $display("FAIL slt_signed res=%h zero=%b required res=0 zero=1", ULAsaida, zero);
      end
   endtask

   task automatic test_logic;
      logic [3:0]  ops [5] = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1111};
      logic [31:0] exp [5] = '{32'hFFF0_FFF0, 32'h000F_000F, 32'h0FF0_0FF0, 32'h0FFF_0FFF, 32'h0};
      int lat, ocup;
      for (int i = 0; i < 5; i++) begin
         executa(ops[i], 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 5, lat, ocup);
         checks++;
         if ({lat, ULAsaida, cout} !== {32'd1, exp[i], 1'b0}) begin
            failures++;
            $display("FAIL logic_op%b lat=%0d res=%h cout=%b required lat=1 res=%h cout=0",
                     ops[i], lat, ULAsaida, cout, exp[i]);
         end
      end
   endtask

   task automatic test_multu;
      int lat, ocup;
      executa(4'b1000, 32'h0001_0000, 32'h0001_0003, 1'b0, 40, lat, ocup);
      checks++;
      if ({lat, ocup} !== {32'd33, 32'd32}) begin
         failures++;
         $display("FAIL multu_timing lat=%0d ocupado_cycles=%0d required lat=33 ocupado_cycles=32", lat, ocup);
      end
      checks++;
      if ({hi, ULAsaida, zero, cout} !== {32'h1, 32'h0003_0000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL multu_result hi=%h lo=%h zero=%b cout=%b required hi=1 lo=00030000 zero=0 cout=0",
                  hi, ULAsaida, zero, cout);
      end
      executa(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 40, lat, ocup);
      checks++;
      if ({hi, ULAsaida} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
         failures++;
         $display("FAIL multu_max hi=%h lo=%h required hi=fffffffe lo=00000001", hi, ULAsaida);
      end
   endtask

   task automatic test_divu;
      int lat, ocup;
      executa(4'b1001, 32'd100, 32'd7, 1'b0, 40, lat, ocup);
      checks++;
      if ({lat, ULAsaida, hi, div_zero} !== {32'd33, 32'd14, 32'd2, 1'b0}) begin
         failures++;
         $display("FAIL divu lat=%0d q=%h r=%h dz=%b required lat=33 q=e r=2 dz=0", lat, ULAsaida, hi, div_zero);
      end
      executa(4'b1001, 32'd9, 32'd0, 1'b0, 40, lat, ocup);
      checks++;
      if ({ULAsaida, hi, div_zero} !== {32'hFFFF_FFFF, 32'd9, 1'b1}) begin
         failures++;
         $display("FAIL divu_by_zero q=%h r=%h dz=%b required q=ffffffff r=9 dz=1", ULAsaida, hi, div_zero);
      end
   endtask

   task automatic test_abort;
      int lat, ocup;
      bit viu_pronto = 0;
      @(negedge clk);
      ULAcontrole = 4'b1000; a = 32'd3; b = 32'd5; inicio = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         inicio = 1'b0;
         if (pronto) viu_pronto = 1;
         if (n == 5) begin
            ULAcontrole = 4'b0000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; inicio = 1'b1;
         end
         if (n == 6) begin
            checks++;
            if ({ocupado, pronto} !== 2'b10) begin
               failures++;
               $display("FAIL ignored_inicio ocupado=%b pronto=%b required ocupado=1 pronto=0", ocupado, pronto);
            end
         end
         if (n == 10) reset = 1'b1;
      end
      @(negedge clk);
      if (pronto) viu_pronto = 1;
      reset = 1'b0;
      checks++;
      if ({ocupado, pronto, ULAsaida, hi, cout, zero, div_zero} !== '0) begin
         failures++;
         $display("FAIL abort_outputs got=%h required=0",
                  {ocupado, pronto, ULAsaida, hi, cout, zero, div_zero});
      end
      repeat (3) begin
         @(negedge clk);
         if (pronto) viu_pronto = 1;
      end
      checks++;
      if (viu_pronto !== 1'b0) begin failures++; $display("FAIL abort_pronto got=1 required=0"); end
      executa(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5, lat, ocup);
      checks++;
      if ({lat, ULAsaida, div_zero} !== {32'd1, 32'hF000_F000, 1'b0}) begin
         failures++;
         $display("FAIL and_after_abort lat=%0d res=%h dz=%b required lat=1 res=f000f000 dz=0",
                  lat, ULAsaida, div_zero);
      end
   endtask

   task automatic test_back_to_back;
      int lat, ocup;
      executa(4'b1000, 32'h0001_0000, 32'h0001_0003, 1'b0, 40, lat, ocup);
      checks++;
      if ({lat, hi} !== {32'd33, 32'h1}) begin
         failures++;
         $display("FAIL b2b_multu lat=%0d hi=%h required lat=33 hi=1", lat, hi);
      end
      executa(4'b0100, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 5, lat, ocup);
      checks++;
      if ({lat, ULAsaida, hi, cout} !== {32'd1, 32'h1D3B_5977, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL b2b_xor lat=%0d res=%h hi=%h cout=%b required lat=1 res=1d3b5977 hi=0 cout=0",
                  lat, ULAsaida, hi, cout);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub_slt;
      test_logic;
      test_multu;
      test_divu;
      test_abort;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
